// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: packet layout and port count.
// Imported by the arbiter, its picker and downstream consumers.
package wb_arbiter_pkg;

  localparam int NUM_WB_PORTS = 2;

  localparam int WB_PREG_W = 7;
  localparam int WB_DATA_W = 32;
  localparam int WB_ROB_W  = 5;

  typedef struct packed {
    logic [WB_PREG_W-1:0] pd;
    logic [WB_DATA_W-1:0] data;
    logic [WB_ROB_W-1:0]  rob;
  } wb_pkt_t;

endpackage

// File: rtl/wb_arbiter_pick2.sv
// Combinational 2-of-N rotate-priority picker.
// Ports: req_i/ptr_i in; gnt0_o/gnt1_o one-hot, any0_o/any1_o, last_idx_o out.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt0_o,
  output logic [N-1:0]  gnt1_o,
  output logic          any0_o,
  output logic          any1_o,
  output logic [PW-1:0] last_idx_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt0_o     = '0;
    gnt1_o     = '0;
    any0_o     = 1'b0;
    any1_o     = 1'b0;
    last_idx_o = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      // walk ptr, ptr+1, ... wrapping modulo N
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (req_i[idx]) begin
        if (!any0_o) begin
          gnt0_o[idx] = 1'b1;
          any0_o      = 1'b1;
          last_idx_o  = idx;
        end else if (!any1_o) begin
          gnt1_o[idx] = 1'b1;
          any1_o      = 1'b1;
          last_idx_o  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to 2 FU results per cycle round-robin
// and registers them onto the 2 regfile write / CDB ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int PREG_W = WB_PREG_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int ROB_W  = WB_ROB_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [NUM_FU-1:0]                     fu_valid,
  output logic [NUM_FU-1:0]                     fu_ready,
  input  logic [NUM_FU-1:0][PREG_W-1:0]         fu_pd,
  input  logic [NUM_FU-1:0][DATA_W-1:0]         fu_data,
  input  logic [NUM_FU-1:0][ROB_W-1:0]          fu_rob,
  output logic [NUM_WB_PORTS-1:0]               wb_we,
  output logic [NUM_WB_PORTS-1:0][PREG_W-1:0]   wb_pd,
  output logic [NUM_WB_PORTS-1:0][DATA_W-1:0]   wb_data,
  output logic [NUM_WB_PORTS-1:0]               cdb_valid,
  output logic [NUM_WB_PORTS-1:0][ROB_W-1:0]    cdb_rob
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
  } pkt_t;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] gnt0, gnt1;
  logic              any0, any1;
  logic [PTR_W-1:0]  last_idx;

  logic              accept;
  logic [1:0]        vld_d;
  pkt_t              sel0, sel1;

  logic [1:0]        we_q, cdb_valid_q;
  pkt_t              pkt0_q, pkt1_q;

  rr_pick2 #(
    .N  (NUM_FU),
    .PW (PTR_W)
  ) u_pick (
    .req_i      (fu_valid),
    .ptr_i      (rr_ptr_q),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .any0_o     (any0),
    .any1_o     (any1),
    .last_idx_o (last_idx)
  );

  // reset and flush both squash the grant seen by the FUs
  assign accept   = rst && !flush;
  assign fu_ready = accept ? (gnt0 | gnt1) : '0;
  assign vld_d    = accept ? {any1, any0} : 2'b00;

  always_comb begin
    sel0 = '0;
    sel1 = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt0[i]) sel0 = '{pd: fu_pd[i], data: fu_data[i], rob: fu_rob[i]};
      if (gnt1[i]) sel1 = '{pd: fu_pd[i], data: fu_data[i], rob: fu_rob[i]};
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (vld_d[0]) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_FU-1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      we_q        <= '0;
      cdb_valid_q <= '0;
      pkt0_q      <= '0;
      pkt1_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= vld_d;
      // p0 completes in the ROB but is never written
      we_q[0]     <= vld_d[0] && (sel0.pd != '0);
      we_q[1]     <= vld_d[1] && (sel1.pd != '0);
      if (vld_d[0]) pkt0_q <= sel0;
      if (vld_d[1]) pkt1_q <= sel1;
    end
  end

  assign wb_we      = we_q;
  assign cdb_valid  = cdb_valid_q;
  assign wb_pd[0]   = pkt0_q.pd;
  assign wb_pd[1]   = pkt1_q.pd;
  assign wb_data[0] = pkt0_q.data;
  assign wb_data[1] = pkt1_q.data;
  assign cdb_rob[0] = pkt0_q.rob;
  assign cdb_rob[1] = pkt1_q.rob;

  // two writes to the same real preg in one cycle must never happen
  a_no_dup_pd: assert property (
    @(posedge clk) disable iff (!rst)
    (accept && any1) |-> ((sel0.pd != sel1.pd) || (sel0.pd == '0))
  );

endmodule
